// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator-side load/store unit between the pipeline MEM stage and a
//   word-organised data memory. Each accepted byte-addressed RV32I access
//   becomes a word index plus byte-lane strobes. The request is held until the
//   memory acknowledges, and the unit returns an extended load result or a fault.
//   A watchdog bounds every memory wait.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses fault with cause 01.
//     undefined : low address bits are forced to natural alignment.
//   Undefined funct3 encodings always fault with cause 01.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     pipeline request handshake
//   req_we, req_funct3      store flag, access type
//   req_addr, req_wdata     byte address, store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata              load result (0 for stores and faults)
//   resp_fault/resp_cause   fault flag, cause (01 misalign, 10 timeout, 11 range)
//   mem_req/mem_we          memory request, write enable
//   mem_addr                word index
//   mem_wdata/mem_wstrb     lane-replicated store data, byte strobes
//   mem_rdata/mem_ready     read word, memory acknowledge
module load_store_unit #(
  parameter int MEM_AW         = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10} state_t;

  state_t            state_r, state_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [2:0]        funct3_r, funct3_s;
  logic [1:0]        lane_r, lane_s;
  logic              req_ready_r, req_ready_s;
  logic              resp_valid_r, resp_valid_s;
  logic [31:0]       resp_rdata_r, resp_rdata_s;
  logic              resp_fault_r, resp_fault_s;
  logic [1:0]        resp_cause_r, resp_cause_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic [3:0]        mem_wstrb_r, mem_wstrb_s;
  logic [1:0]        lo_s;

  // Encodings with no RV32I load/store meaning (unsigned stores included).
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == 3'b010) && (lo != 2'b00));
  endfunction

  // Natural alignment of the low address bits (no-op for aligned accesses).
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] r;
    case (f3[1:0])
      2'b01:   r = {lo[1], 1'b0};
      2'b10:   r = 2'b00;
      default: r = lo;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << lo;
      3'b001:  s = lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      3'b010:  r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      2'b11:   b = d[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    funct3_s     = funct3_r;
    lane_s       = lane_r;
    resp_valid_s = 1'b0;
    resp_rdata_s = resp_rdata_r;
    resp_fault_s = resp_fault_r;
    resp_cause_s = resp_cause_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    mem_wstrb_s  = mem_wstrb_r;
    lo_s         = align_lo(req_funct3, req_addr[1:0]);
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (f3_illegal(req_we, req_funct3) ||
              (TRAP_EN && f3_misaligned(req_funct3, req_addr[1:0]))) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 32'h0000_0000;
            resp_fault_s = 1'b1;
            resp_cause_s = 2'b01;
          end else if (req_addr[31:MEM_AW+2] != '0) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 32'h0000_0000;
            resp_fault_s = 1'b1;
            resp_cause_s = 2'b11;
          end else begin
            state_s     = REQ;
            cnt_s       = 8'd0;
            funct3_s    = req_funct3;
            lane_s      = lo_s;
            mem_req_s   = 1'b1;
            mem_we_s    = req_we;
            mem_addr_s  = req_addr[MEM_AW+1:2];
            mem_wdata_s = req_we ? store_data(req_funct3, req_wdata) : 32'h0000_0000;
            mem_wstrb_s = req_we ? store_strb(req_funct3, lo_s) : 4'b0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = mem_we_r ? 32'h0000_0000 : load_extract(funct3_r, lane_r, mem_rdata);
          resp_fault_s = 1'b0;
          resp_cause_s = 2'b00;
          mem_req_s    = 1'b0;
          mem_we_s     = 1'b0;
          mem_wstrb_s  = 4'b0000;
        end else if (cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the request; the memory must ignore it once mem_req drops.
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = 32'h0000_0000;
          resp_fault_s = 1'b1;
          resp_cause_s = 2'b10;
          mem_req_s    = 1'b0;
          mem_we_s     = 1'b0;
          mem_wstrb_s  = 4'b0000;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and all outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r        <= 8'd0;
      funct3_r     <= 3'b000;
      lane_r       <= 2'b00;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
      resp_cause_r <= 2'b00;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wstrb_r  <= 4'b0000;
    end else begin
      cnt_r        <= cnt_s;
      funct3_r     <= funct3_s;
      lane_r       <= lane_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_fault_r <= resp_fault_s;
      resp_cause_r <= resp_cause_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_wstrb_r  <= mem_wstrb_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_fault = resp_fault_r;
  assign resp_cause = resp_cause_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wstrb  = mem_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. Expected responses (data, fault,
//   cause, completion cycle) are pushed to a scoreboard when a request is
//   accepted and compared by a monitor whenever resp_valid is seen.
//   Follows LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_load_store_unit;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [1:0]    resp_cause;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ready = 1'b0;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.MEM_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_cause(resp_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      check_eq("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_rdata", resp_rdata, e.rdata);
        check_eq("resp_fault", 32'(resp_fault), 32'(e.fault));
        check_eq("resp_cause", 32'(resp_cause), 32'(e.cause));
        check_eq("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    check_eq("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // Drive one access; wait_n >= TO means the memory never acknowledges.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mword, input int wait_n,
                       input bit to_mem, input logic [AW-1:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                       input logic e_fault, input logic [1:0] e_cause);
    exp_t e;
    int   n;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    e.rdata = e_rdata; e.fault = e_fault; e.cause = e_cause;
    e.cyc = cyc + (!to_mem ? 0 : (wait_n < TO ? 1 + wait_n : TO));
    sb.push_back(e);
    @(negedge clk);
    if (to_mem) begin
      check_eq("mem_req", 32'(mem_req), 32'd1);
      check_eq("req_ready_busy", 32'(req_ready), 32'd0);
      check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
      check_eq("mem_we", 32'(mem_we), 32'(we));
      check_eq("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
      check_eq("mem_wdata", mem_wdata, e_wdata);
      if (wait_n < TO) begin
        repeat (wait_n) @(negedge clk);
        check_eq("mem_req_hold", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = mword;
        @(posedge clk);
        #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
      end else begin
        n = 0;
        for (int i = 0; i < TO + 4; i++) begin
          if (mem_req) n++;
          @(negedge clk);
        end
        check_eq("timeout_req_cycles", 32'(n), 32'(TO));
      end
    end else begin
      check_eq("no_mem_req", 32'(mem_req), 32'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #12;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
    check_eq("rst_resp_cause", 32'(resp_cause), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    //    we    f3      addr          wdata         mword         wt  mem  maddr  strb     e_wdata       e_rdata       flt   cause
    issue(1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'h0000_0017, 0, 1, 6'd2,  4'b0000, 32'h0,        32'h0000_0017, 1'b0, 2'b00);
    issue(1'b0, 3'b000, 32'h0000_000D, 32'h0,        32'h1234_80FF, 0, 1, 6'd3,  4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 2'b00);
    issue(1'b0, 3'b100, 32'h0000_000D, 32'h0,        32'h1234_80FF, 1, 1, 6'd3,  4'b0000, 32'h0,        32'h0000_0080, 1'b0, 2'b00);
    issue(1'b1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 32'h0,        2, 1, 6'd1,  4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 2'b00);
    issue(1'b1, 3'b000, 32'h0000_0003, 32'h1234_565A, 32'h0,        0, 1, 6'd0,  4'b1000, 32'h5A5A_5A5A, 32'h0,        1'b0, 2'b00);
    issue(1'b1, 3'b010, 32'h0000_003C, 32'hDEAD_BEEF, 32'h0,        0, 1, 6'd15, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 2'b00);
    issue(1'b0, 3'b001, 32'h0000_001E, 32'h0,        32'h8001_7FFF, 1, 1, 6'd7,  4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 2'b00);
    issue(1'b0, 3'b101, 32'h0000_001C, 32'h0,        32'h8001_7FFF, 0, 1, 6'd7,  4'b0000, 32'h0,        32'h0000_7FFF, 1'b0, 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'hCAFE_F00D, 0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b01);
    issue(1'b0, 3'b001, 32'h0000_0005, 32'h0,        32'h1122_3344, 0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b01);
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b01);
`else
    issue(1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'hCAFE_F00D, 0, 1, 6'd0,  4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 2'b00);
    issue(1'b0, 3'b001, 32'h0000_0005, 32'h0,        32'h1122_3344, 0, 1, 6'd1,  4'b0000, 32'h0,        32'h0000_3344, 1'b0, 2'b00);
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b11);
`endif
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b01);
    issue(1'b1, 3'b100, 32'h0000_0004, 32'h0000_0011, 32'h0,        0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b01);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 6'd0,  4'b0000, 32'h0,        32'h0,        1'b1, 2'b11);
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h0,        TO, 1, 6'd4, 4'b0000, 32'h0,        32'h0,        1'b1, 2'b10);
    issue(1'b0, 3'b010, 32'h0000_0014, 32'h0,        32'h600D_0001, TO-1, 1, 6'd5, 4'b0000, 32'h0,     32'h600D_0001, 1'b0, 2'b00);

    // mem_ready while idle must not start anything or produce a response.
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_ready_ignored", 32'(mem_req), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);

    // Reset during a waiting request: no response, unit idle afterwards.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);

    issue(1'b0, 3'b010, 32'h0000_00FC, 32'h0,        32'h0BAD_F00D, 0, 1, 6'd63, 4'b0000, 32'h0,        32'h0BAD_F00D, 1'b0, 2'b00);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
